// File: rtl/uart_rx_ctrl_pkg.sv
// rtl/uart_rx_ctrl_pkg.sv - shared states, legal prescale values and reset defaults for uart_rx_ctrl
package uart_rx_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    APPLY = 2'd2
  } state_t;

  localparam logic [5:0] PRESCALE_8  = 6'd8;
  localparam logic [5:0] PRESCALE_16 = 6'd16;
  localparam logic [5:0] PRESCALE_32 = 6'd32;

  localparam logic RST_PAR_EN  = 1'b1;
  localparam logic RST_PAR_TYP = 1'b0;

  function automatic logic prescale_legal(input logic [5:0] p);
    return (p == PRESCALE_8) || (p == PRESCALE_16) || (p == PRESCALE_32);
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_fifo.sv
// rtl/uart_rx_ctrl_fifo.sv - synchronous FIFO for received bytes, push accepted when full if a pop coincides
module uart_rx_ctrl_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  // Storage carries no reset: head data is don't-care while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART_RX config scheduler, byte FIFO and error counters; UART_RX_CTRL_DROP_PERR_EN drops parity-errored bytes
module uart_rx_ctrl
  import uart_rx_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int CNT_WIDTH    = 8,
  parameter int RST_PRESCALE = 32
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Rx_in,
  input  logic                  Cfg_Wr,
  input  logic [5:0]            Cfg_Prescale,
  input  logic                  Cfg_Par_En,
  input  logic                  Cfg_Par_Typ,
  output logic                  Cfg_Rej,
  output logic                  Cfg_Pend,
  output logic [5:0]            Prescale,
  output logic                  Parity_En,
  output logic                  Parity_Typ,
  input  logic [DATA_WIDTH-1:0] P_Data,
  input  logic                  Data_Valid,
  input  logic                  Parity_Err,
  input  logic                  Framing_Err,
  output logic [DATA_WIDTH-1:0] Out_Data,
  output logic                  Out_Perr,
  output logic                  Out_Valid,
  input  logic                  Out_Ready,
  output logic                  Busy,
  output logic [CNT_WIDTH-1:0]  Perr_Cnt,
  output logic [CNT_WIDTH-1:0]  Ferr_Cnt,
  output logic [CNT_WIDTH-1:0]  Ovf_Cnt
);

  state_t       state;
  logic         rx_s1;
  logic         rx_s2;
  logic         rx_d;
  logic         start;
  logic [9:0]   frame_cnt;
  logic [9:0]   frame_limit;
  logic [5:0]   sh_prescale;
  logic         sh_par_en;
  logic         sh_par_typ;
  logic         cfg_ok;

  logic         push_req;
  logic         push_perr;
  logic         pop;
  logic         fifo_full;
  logic         fifo_empty;
  logic         ovf;
  logic [DATA_WIDTH:0] fifo_rdata;

  assign start  = rx_d & ~rx_s2;
  assign cfg_ok = Cfg_Wr & prescale_legal(Cfg_Prescale);
  // One bit time of guard past the stop bit before abandoning a frame.
  assign frame_limit = 10'(Prescale) * (Parity_En ? 10'd12 : 10'd11) - 10'd1;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state       <= IDLE;
      rx_s1       <= 1'b1;
      rx_s2       <= 1'b1;
      rx_d        <= 1'b1;
      frame_cnt   <= '0;
      Busy        <= 1'b0;
      Prescale    <= 6'(RST_PRESCALE);
      Parity_En   <= RST_PAR_EN;
      Parity_Typ  <= RST_PAR_TYP;
      sh_prescale <= 6'(RST_PRESCALE);
      sh_par_en   <= RST_PAR_EN;
      sh_par_typ  <= RST_PAR_TYP;
      Cfg_Pend    <= 1'b0;
      Cfg_Rej     <= 1'b0;
    end else begin
      rx_s1   <= Rx_in;
      rx_s2   <= rx_s1;
      rx_d    <= rx_s2;
      Cfg_Rej <= Cfg_Wr & ~prescale_legal(Cfg_Prescale);

      if (cfg_ok) begin
        sh_prescale <= Cfg_Prescale;
        sh_par_en   <= Cfg_Par_En;
        sh_par_typ  <= Cfg_Par_Typ;
      end

      // A write landing in the APPLY cycle keeps the flag set for the next round.
      if (cfg_ok)
        Cfg_Pend <= 1'b1;
      else if (state == APPLY)
        Cfg_Pend <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            state     <= BUSY;
            Busy      <= 1'b1;
            frame_cnt <= '0;
          end else if (Cfg_Pend) begin
            state <= APPLY;
          end
        end
        BUSY: begin
          if (Data_Valid || Framing_Err || (frame_cnt == frame_limit)) begin
            state <= IDLE;
            Busy  <= 1'b0;
          end else begin
            frame_cnt <= frame_cnt + 10'd1;
          end
        end
        APPLY: begin
          Prescale   <= sh_prescale;
          Parity_En  <= sh_par_en;
          Parity_Typ <= sh_par_typ;
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef UART_RX_CTRL_DROP_PERR_EN
  assign push_req  = Data_Valid & ~Parity_Err;
  assign push_perr = 1'b0;
`else
  assign push_req  = Data_Valid;
  assign push_perr = Parity_Err;
`endif

  assign Out_Valid = ~fifo_empty;
  assign pop       = Out_Valid & Out_Ready;
  assign ovf       = push_req & fifo_full & ~pop;
  assign Out_Data  = fifo_rdata[DATA_WIDTH-1:0];
  assign Out_Perr  = fifo_rdata[DATA_WIDTH];

  uart_rx_ctrl_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (Clk),
    .rst   (Rst),
    .push  (push_req),
    .pop   (pop),
    .wdata ({push_perr, P_Data}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      Perr_Cnt <= '0;
      Ferr_Cnt <= '0;
      Ovf_Cnt  <= '0;
    end else begin
      if (Data_Valid && Parity_Err && (Perr_Cnt != {CNT_WIDTH{1'b1}}))
        Perr_Cnt <= Perr_Cnt + 1'b1;
      if (Framing_Err && (Ferr_Cnt != {CNT_WIDTH{1'b1}}))
        Ferr_Cnt <= Ferr_Cnt + 1'b1;
      if (ovf && (Ovf_Cnt != {CNT_WIDTH{1'b1}}))
        Ovf_Cnt <= Ovf_Cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - randomized scoreboard bench for uart_rx_ctrl against a frame-level reference model
module tb_uart_rx_ctrl;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int CW    = 8;

  logic          TX_CLK_TB = 1'b0;
  logic          rst, rx_in, cfg_wr, cfg_par_en, cfg_par_typ;
  logic [5:0]    cfg_prescale;
  logic          cfg_rej, cfg_pend, parity_en, parity_typ;
  logic [5:0]    prescale;
  logic [DW-1:0] p_data, out_data;
  logic          data_valid, parity_err, framing_err;
  logic          out_perr, out_valid, out_ready, busy;
  logic [CW-1:0] perr_cnt, ferr_cnt, ovf_cnt;

  always #5 TX_CLK_TB = ~TX_CLK_TB;

  uart_rx_ctrl #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW), .RST_PRESCALE(32)) dut (
    .Clk(TX_CLK_TB), .Rst(rst), .Rx_in(rx_in), .Cfg_Wr(cfg_wr), .Cfg_Prescale(cfg_prescale),
    .Cfg_Par_En(cfg_par_en), .Cfg_Par_Typ(cfg_par_typ), .Cfg_Rej(cfg_rej), .Cfg_Pend(cfg_pend),
    .Prescale(prescale), .Parity_En(parity_en), .Parity_Typ(parity_typ), .P_Data(p_data),
    .Data_Valid(data_valid), .Parity_Err(parity_err), .Framing_Err(framing_err),
    .Out_Data(out_data), .Out_Perr(out_perr), .Out_Valid(out_valid), .Out_Ready(out_ready),
    .Busy(busy), .Perr_Cnt(perr_cnt), .Ferr_Cnt(ferr_cnt), .Ovf_Cnt(ovf_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: active/pending config, expected FIFO contents, error tallies.
  logic [5:0] m_pre, p_pre;
  bit         m_pen, m_typ, p_pen, p_typ, p_pend;
  int         m_perr, m_ferr, m_ovf;
  logic [8:0] sb [$];
  int         rdy_mode;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v < (1 << CW) - 1) ? v + 1 : v;
  endfunction

  task automatic tick();
    @(posedge TX_CLK_TB);
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic model_cfg(input logic [5:0] pre, input bit pen, input bit typ);
    if (pre == 6'd8 || pre == 6'd16 || pre == 6'd32) begin
      p_pre = pre; p_pen = pen; p_typ = typ; p_pend = 1;
    end
  endtask

  task automatic cfg_write(input logic [5:0] pre, input bit pen, input bit typ);
    cfg_prescale = pre; cfg_par_en = pen; cfg_par_typ = typ; cfg_wr = 1'b1;
    model_cfg(pre, pen, typ);
    tick();
    cfg_wr = 1'b0;
  endtask

  // Line idle long enough for a pending config to be applied.
  task automatic settle();
    rx_in = 1'b1;
    repeat (6) tick();
    if (p_pend) begin
      m_pre = p_pre; m_pen = p_pen; m_typ = p_typ; p_pend = 0;
    end
  endtask

  task automatic model_push(input logic [8:0] v);
    bit pop_pending;
    pop_pending = out_ready && (sb.size() > 0);
    if (sb.size() >= DEPTH && !pop_pending) m_ovf = sat(m_ovf);
    else sb.push_back(v);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit ferr,
                            input bit mid, input logic [5:0] mpre, input bit mpen, input bit mtyp,
                            input bit pulse_pop);
    int  bt;
    bit  par_bit;
    bit  perr;
    bt = int'(m_pre);
    par_bit = (^d) ^ m_typ ^ bad_par;
    check("prescale_active", prescale, m_pre);
    rx_in = 1'b0;
    repeat (bt) tick();
    if (mid) begin
      cfg_prescale = mpre; cfg_par_en = mpen; cfg_par_typ = mtyp; cfg_wr = 1'b1;
      model_cfg(mpre, mpen, mtyp);
      tick();
      cfg_wr = 1'b0;
    end
    for (int i = 0; i < 8; i++) begin
      rx_in = d[i];
      repeat (bt) tick();
    end
    if (m_pen) begin
      rx_in = par_bit;
      repeat (bt) tick();
    end
    rx_in = 1'b1;
    repeat (bt / 2) tick();
    check("busy_in_frame", busy, 1);
    if (pulse_pop) out_ready = 1'b1;
    if (ferr) begin
      framing_err = 1'b1;
      m_ferr = sat(m_ferr);
    end else begin
      perr = m_pen && bad_par;
      data_valid = 1'b1; p_data = d; parity_err = perr;
      if (perr) m_perr = sat(m_perr);
`ifdef UART_RX_CTRL_DROP_PERR_EN
      if (!perr) model_push({1'b0, d});
`else
      model_push({perr, d});
`endif
    end
    tick();
    data_valid = 1'b0; parity_err = 1'b0; framing_err = 1'b0;
    check("busy_fall", busy, 0);
  endtask

  task automatic drain();
    rdy_mode = 1;
    for (int i = 0; i < 50 && sb.size() > 0; i++) tick();
    tick();
    check("drain_empty", sb.size(), 0);
    check("out_valid_drained", out_valid, 0);
  endtask

  // Monitor: a transfer is due at the next rising edge whenever valid and ready are both up.
  always @(negedge TX_CLK_TB) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_byte", out_data, 0);
        check("unexpected_byte_valid", out_valid, 0);
      end else begin
        logic [8:0] e;
        e = sb.pop_front();
        check("out_data", out_data, e[7:0]);
        check("out_perr", out_perr, e[8]);
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [5:0] ptab [4];
    int n, t;
    ptab[0] = 6'd8; ptab[1] = 6'd16; ptab[2] = 6'd32; ptab[3] = 6'd20;
    rst = 1'b1; rx_in = 1'b1; cfg_wr = 1'b0; cfg_prescale = '0; cfg_par_en = 1'b0; cfg_par_typ = 1'b0;
    p_data = '0; data_valid = 1'b0; parity_err = 1'b0; framing_err = 1'b0; out_ready = 1'b0;
    rdy_mode = 1;
    m_pre = 6'd32; m_pen = 1; m_typ = 0; p_pre = 6'd32; p_pen = 1; p_typ = 0; p_pend = 0;
    m_perr = 0; m_ferr = 0; m_ovf = 0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_prescale", prescale, 32);
    check("rst_par_en", parity_en, 1);
    check("rst_par_typ", parity_typ, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_perr", perr_cnt, 0);
    check("rst_ferr", ferr_cnt, 0);
    check("rst_ovf", ovf_cnt, 0);
    check("rst_cfg_pend", cfg_pend, 0);
    check("rst_busy", busy, 0);

    // Odd parity, prescale 32, then 0xBB.
    cfg_write(6'd32, 1, 1);
    check("cfg_pend_set", cfg_pend, 1);
    settle();
    check("odd_applied", parity_typ, 1);
    check("cfg_pend_clear", cfg_pend, 0);
    send_frame(8'hBB, 0, 0, 0, 0, 0, 0, 0);
    settle();

    // Mid-frame config change is held until the frame ends.
    send_frame(8'h3C, 0, 0, 1, 6'd16, 1, 1, 0);
    check("mid_cfg_pend", cfg_pend, 1);
    check("mid_prescale_held", prescale, 32);
    settle();
    check("mid_prescale_applied", prescale, 16);
    check("mid_pend_clear", cfg_pend, 0);

    // Illegal prescale rejected.
    cfg_write(6'd20, 0, 0);
    check("rej_pulse", cfg_rej, 1);
    tick();
    check("rej_once", cfg_rej, 0);
    check("rej_pend", cfg_pend, 0);
    check("rej_prescale", prescale, 16);
    check("rej_par_en", parity_en, 1);
    settle();

    // Overflow: five frames with nobody reading.
    rdy_mode = 0;
    for (int i = 0; i < 5; i++) begin
      send_frame(8'($urandom), 0, 0, 0, 0, 0, 0, 0);
      settle();
    end
    check("ovf_one", ovf_cnt, 1);
    check("ovf_model", ovf_cnt, m_ovf);
    check("full_valid", out_valid, 1);
    send_frame(8'h5A, 0, 0, 0, 0, 0, 0, 1);
    settle();
    check("pop_push_no_ovf", ovf_cnt, 1);
    drain();
    settle();

    // Wrong parity bit, then a framing error.
    send_frame(8'hA5, 1, 0, 0, 0, 0, 0, 0);
    settle();
    check("perr_one", perr_cnt, 1);
    send_frame(8'h11, 0, 1, 0, 0, 0, 0, 0);
    settle();
    check("ferr_one", ferr_cnt, 1);

    // Start glitch times out after the guard interval.
    rx_in = 1'b0; tick(); tick(); rx_in = 1'b1;
    for (int i = 0; i < 20 && !busy; i++) tick();
    check("glitch_busy", busy, 1);
    n = 0;
    while (busy && n < 1000) begin tick(); n++; end
    t = int'(m_pre) * (11 + int'(m_pen));
    check("glitch_timeout", (n >= t - 1 && n <= t + 1) ? t : n, t);
    settle();

    // Randomized traffic with config churn and back-pressure.
    rdy_mode = 2;
    for (int k = 0; k < 14; k++) begin
      if ($urandom_range(0, 2) == 0) begin
        cfg_write(ptab[$urandom_range(0, 3)], 1'($urandom), 1'($urandom));
        settle();
      end
      send_frame(8'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 3) == 0), ptab[$urandom_range(0, 3)], 1'($urandom),
                 1'($urandom), 0);
      settle();
    end
    drain();
    check("rand_perr", perr_cnt, m_perr);
    check("rand_ferr", ferr_cnt, m_ferr);
    check("rand_ovf", ovf_cnt, m_ovf);
    check("rand_prescale", prescale, m_pre);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
